led_chain_transmitter: RTL

//  Parametrised WS281x-style serial pixel transmitter driving one LED data line.

---
 rtl/led_chain_transmitter_pkg.sv | 27 ++
 rtl/led_chain_transmitter_bit_encoder.sv | 55 +++++
 rtl/led_chain_transmitter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/led_chain_transmitter_pkg.sv
// Shared definitions for the WS281x LED chain transmitter: FSM state
// encoding, default WS2812 timing at a 50 MHz clock, and sizing helpers.
package led_chain_transmitter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } tx_state_t;

  // WS2812 timing at 50 MHz (20 ns per cycle)
  localparam int WS2812_T0H_CYC   = 20;    // 400 ns
  localparam int WS2812_T1H_CYC   = 40;    // 800 ns
  localparam int WS2812_BIT_CYC   = 63;    // 1.26 us
  localparam int WS2812_RESET_CYC = 3000;  // 60 us latch gap

  // Index width for a range of v entries, never narrower than one bit
  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_chain_transmitter_bit_encoder.sv
// ws_bit_encoder: turns one bit strobe into a BIT_CYC-long waveform on a
// registered line, high for T1H_CYC ('1') or T0H_CYC ('0') cycles.
// hi_done marks the last high cycle, bit_done the last cycle of the bit;
// a strobe in the bit_done cycle starts the next bit with no gap.
module ws_bit_encoder
  import led_chain_transmitter_pkg::*;
#(
  parameter int T0H_CYC = WS2812_T0H_CYC,
  parameter int T1H_CYC = WS2812_T1H_CYC,
  parameter int BIT_CYC = WS2812_BIT_CYC,
  parameter int CNT_W   = clog2_min1(BIT_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_stb,
  input  logic bit_val,
  output logic dout,
  output logic hi_done,
  output logic bit_done
);

  logic             active_q;
  logic             val_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] hi_len;

  assign hi_len   = val_q ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
  assign hi_done  = active_q && (cnt_q == hi_len - 1'b1);
  assign bit_done = active_q && (cnt_q == CNT_W'(BIT_CYC - 1));

  // Bit-period counter and registered line level
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      val_q    <= 1'b0;
      cnt_q    <= '0;
      dout     <= 1'b0;
    end else if (bit_stb) begin
      active_q <= 1'b1;
      val_q    <= bit_val;
      cnt_q    <= '0;
      dout     <= 1'b1;
    end else if (active_q) begin
      if (bit_done) begin
        active_q <= 1'b0;
        cnt_q    <= '0;
        dout     <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        dout  <= ((cnt_q + 1'b1) < hi_len);
      end
    end
  end

endmodule

// File: rtl/led_chain_transmitter.sv
// led_chain_transmitter: snapshots NUM_LEDS pixel words on an accepted start
// and shifts them out LED0 first, MSB first, followed by a RESET_CYC low
// latch gap. The final latch cycle already reports ready/done so a held
// start chains frames separated by exactly RESET_CYC low cycles.
// Optional debug outputs are enabled by defining LED_TX_DBG_EN.
module led_chain_transmitter
  import led_chain_transmitter_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int BITS_PER_LED = 24,
  parameter int T0H_CYC      = WS2812_T0H_CYC,
  parameter int T1H_CYC      = WS2812_T1H_CYC,
  parameter int BIT_CYC      = WS2812_BIT_CYC,
  parameter int RESET_CYC    = WS2812_RESET_CYC
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NUM_LEDS*BITS_PER_LED-1:0] pixels,
  output logic                             ready,
  output logic                             dout,
  output logic                             done,
  output logic                             frame_rqst
`ifdef LED_TX_DBG_EN
  ,
  output logic [clog2_min1(NUM_LEDS)-1:0]  dbg_led_idx,
  output logic [BITS_PER_LED-1:0]          dbg_word
`endif
);

  localparam int TOTAL_BITS = NUM_LEDS * BITS_PER_LED;
  localparam int CNT_W      = clog2_min1(max2(BIT_CYC, RESET_CYC) + 1);
  localparam int BIT_IDX_W  = clog2_min1(BITS_PER_LED);
  localparam int LED_IDX_W  = clog2_min1(NUM_LEDS);
  localparam int BUF_IDX_W  = clog2_min1(TOTAL_BITS);

  if (!(NUM_LEDS >= 1 && BITS_PER_LED >= 1 && T0H_CYC >= 1 &&
        T0H_CYC < T1H_CYC && T1H_CYC < BIT_CYC && RESET_CYC >= 1)) begin : g_bad_params
    $error("led_chain_transmitter: need T0H_CYC>=1, T0H_CYC<T1H_CYC<BIT_CYC, RESET_CYC>=1");
  end

  tx_state_t             state_q, state_d;
  logic [TOTAL_BITS-1:0] frame_buf;
  logic [BIT_IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [LED_IDX_W-1:0]  led_idx_q, led_idx_d;
  logic [CNT_W-1:0]      latch_cnt_q, latch_cnt_d;
  logic [BUF_IDX_W-1:0]  sel;
  logic                  ready_d, done_d, frame_rqst_d;
  logic                  accept, last_bit;
  logic                  bit_stb, bit_val, hi_done, bit_done;

  assign accept   = ready && start;
  assign last_bit = (led_idx_q == LED_IDX_W'(NUM_LEDS - 1)) &&
                    (bit_idx_q == BIT_IDX_W'(BITS_PER_LED - 1));

  ws_bit_encoder #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .BIT_CYC (BIT_CYC),
    .CNT_W   (CNT_W)
  ) u_bit_encoder (
    .clk      (clk),
    .rst      (rst),
    .bit_stb  (bit_stb),
    .bit_val  (bit_val),
    .dout     (dout),
    .hi_done  (hi_done),
    .bit_done (bit_done)
  );

  // Next state, pixel indices, latch count, bit strobes and registered flags
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    led_idx_d    = led_idx_q;
    latch_cnt_d  = latch_cnt_q;
    ready_d      = 1'b0;
    done_d       = 1'b0;
    frame_rqst_d = 1'b0;
    bit_stb      = 1'b0;
    bit_val      = 1'b0;
    sel          = '0;
    case (state_q)
      ST_IDLE: ready_d = 1'b1;
      ST_HIGH: if (hi_done) state_d = ST_LOW;
      ST_LOW: begin
        if (bit_done) begin
          if (last_bit) begin
            state_d     = ST_LATCH;
            latch_cnt_d = '0;
            if (RESET_CYC == 1) begin
              ready_d = 1'b1;
              done_d  = 1'b1;
            end
          end else begin
            state_d = ST_HIGH;
            bit_stb = 1'b1;
            if (bit_idx_q == BIT_IDX_W'(BITS_PER_LED - 1)) begin
              bit_idx_d = '0;
              led_idx_d = led_idx_q + 1'b1;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
            sel     = BUF_IDX_W'(int'(led_idx_d) * BITS_PER_LED + (BITS_PER_LED - 1) - int'(bit_idx_d));
            bit_val = frame_buf[sel];
          end
        end
      end
      ST_LATCH: begin
        if (latch_cnt_q == CNT_W'(RESET_CYC - 1)) begin
          state_d     = ST_IDLE;
          latch_cnt_d = '0;
          ready_d     = 1'b1;
        end else begin
          latch_cnt_d = latch_cnt_q + 1'b1;
          if (int'(latch_cnt_q) + 2 == RESET_CYC) begin
            ready_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // ready is only high in IDLE or the final latch cycle, so acceptance overrides both
    if (accept) begin
      state_d      = ST_HIGH;
      bit_idx_d    = '0;
      led_idx_d    = '0;
      latch_cnt_d  = '0;
      ready_d      = 1'b0;
      done_d       = 1'b0;
      frame_rqst_d = 1'b1;
      bit_stb      = 1'b1;
      bit_val      = pixels[BITS_PER_LED-1];
    end
  end

  // Control registers; reset aborts any frame in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_idx_q   <= '0;
      led_idx_q   <= '0;
      latch_cnt_q <= '0;
      ready       <= 1'b1;
      done        <= 1'b0;
      frame_rqst  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      led_idx_q   <= led_idx_d;
      latch_cnt_q <= latch_cnt_d;
      ready       <= ready_d;
      done        <= done_d;
      frame_rqst  <= frame_rqst_d;
    end
  end

  // Frame snapshot; upstream may change pixels once the frame is accepted
  always_ff @(posedge clk) begin
    if (accept) frame_buf <= pixels;
  end

`ifdef LED_TX_DBG_EN
  logic [BUF_IDX_W-1:0] dbg_base;

  // Word currently on the line, zero outside the bit phases
  always_comb begin
    dbg_base    = BUF_IDX_W'(int'(led_idx_q) * BITS_PER_LED);
    dbg_led_idx = led_idx_q;
    dbg_word    = '0;
    if (state_q == ST_HIGH || state_q == ST_LOW) dbg_word = frame_buf[dbg_base +: BITS_PER_LED];
  end
`endif

endmodule
